// File: rtl/char_loader.sv
// char_loader: packs a byte-serial valid/ready character stream into an
// N-slot window, pads short windows, pulses run to start the embedding
// stage and holds the window stable until the stage reports completion.
module char_loader #(
    parameter int N        = 10,
    parameter int CHAR_LEN = 8,
    parameter int MAX_CHAR = 200,
    parameter int PAD_CHAR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CHAR_LEN-1:0]   in_data,
    input  logic                  in_last,
    output logic                  run,
    output logic [N*CHAR_LEN-1:0] d,
    input  logic                  emb_valid,
    output logic                  busy,
    output logic                  err
);

    localparam int                 CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]      LAST_IDX = CW'(N - 1);
    localparam logic [CHAR_LEN-1:0] PAD     = CHAR_LEN'(PAD_CHAR);

    typedef enum logic [1:0] {
        S_FILL,
        S_PAD,
        S_RUN,
        S_WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [N*CHAR_LEN-1:0]   d_q, d_d;
    logic                    err_q, err_d;
    logic                    emb_valid_q;

    logic                    accept;
    logic                    bad_code;
    logic [CHAR_LEN-1:0]     char_in;

    assign in_ready = (state_q == S_FILL) && !rst;
    assign run      = (state_q == S_RUN);
    assign busy     = (state_q != S_FILL);
    assign d        = d_q;
    assign err      = err_q;

    assign accept   = in_valid && in_ready;
    assign bad_code = (in_data == '0) || (int'(in_data) > MAX_CHAR);
    assign char_in  = bad_code ? PAD : in_data;

    // Next-state, slot write, counter and error-flag decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        err_d   = err_q;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    d_d[int'(cnt_q)*CHAR_LEN +: CHAR_LEN] = char_in;
                    if (bad_code) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (in_last) begin
                            state_d = S_PAD;
                        end
                    end
                end
            end
            S_PAD: begin
                d_d[int'(cnt_q)*CHAR_LEN +: CHAR_LEN] = PAD;
                if (cnt_q == LAST_IDX) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RUN: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (emb_valid && !emb_valid_q) begin
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // State, window and history registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FILL;
            cnt_q       <= '0;
            d_q         <= '0;
            err_q       <= 1'b0;
            emb_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            d_q         <= d_d;
            err_q       <= err_d;
            emb_valid_q <= emb_valid;
        end
    end

endmodule
